cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage of the multicycle ARM core, sitting directly downstream of the multicycle control decoder.
- Holds the architectural NZCV flags and evaluates the instruction's Cond field once per instruction, in the Decode cycle.
- Registers that pass/fail verdict for the rest of the instruction.
- Gates the decoder's raw write enables (PCS, RegW, MemW, NextPC, FlagW, NoWrite) into the committed PCWrite, RegWrite and MemWrite.

Parameters:
- FLAG_RESET, 4'b0000, reset value of the NZCV register.
- COND_NV_EXEC, 0, verdict for Cond=4'b1111 (0 = never execute, 1 = execute).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Cond  in  4  Instr[31:28] from the instruction register.
- ALUFlags  in  4  ALU result flags {N,Z,C,V}.
- FlagW  in  2  [1]: write N,Z; [0]: write C,V (from the ALU decoder).
- PCS  in  1  PC-write request (branch, or Rd=R15 with RegW).
- RegW  in  1  raw register-file write request.
- MemW  in  1  raw memory write request.
- NextPC  in  1  unconditional PC update (Fetch cycle).
- IRWrite  in  1  instruction register loads this cycle (Fetch).
- NoWrite  in  1  suppress the register write (CMP).
- PCWrite  out  1  committed PC enable.
- RegWrite  out  1  committed register-file write.
- MemWrite  out  1  committed memory write.
- Flags  out  4  current NZCV register {N,Z,C,V}.
- CondExReg  out  1  registered execute verdict for the current instruction.

Behaviour:
- State:
  - Flags[3:0], where [3]=N, [2]=Z, [1]=C, [0]=V.
  - CondExReg.
  - dec_cyc: a one-cycle-delayed copy of IRWrite; high during the Decode cycle.
- Reset (synchronous, dominates every other update):
  - Flags <= FLAG_RESET; CondExReg <= 0; dec_cyc <= 0.
  - Applies mid-instruction; no pending write survives.
- dec_cyc <= IRWrite every cycle.
- Combinational CondEx(Cond, Flags) over the register contents, never ALUFlags:
  - 0000 EQ: Z.  0001 NE: ~Z.
  - 0010 CS: C.  0011 CC: ~C.
  - 0100 MI: N.  0101 PL: ~N.
  - 0110 VS: V.  0111 VC: ~V.
  - 1000 HI: C & ~Z.  1001 LS: ~C | Z.
  - 1010 GE: N==V.  1011 LT: N!=V.
  - 1100 GT: ~Z & (N==V).  1101 LE: Z | (N!=V).
  - 1110 AL: 1.  1111: COND_NV_EXEC.
- Verdict capture:
  - When dec_cyc=1: CondExReg <= CondEx.
  - Otherwise CondExReg holds, so the verdict stays fixed through Execute, Memory and Writeback even if the flags change during the instruction.
- Flag update:
  - If FlagW[1] & CondExReg: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0] & CondExReg: Flags[1:0] <= ALUFlags[1:0].
  - Both pairs may update in the same cycle.
  - New flags are visible from the next cycle.
- Outputs, combinational, zero latency:
  - PCWrite = NextPC | (PCS & CondExReg). NextPC is never gated, so Fetch always advances the PC.
  - RegWrite = RegW & CondExReg & ~NoWrite.
  - MemWrite = MemW & CondExReg.
- Simultaneous dec_cyc and nonzero FlagW:
  - The flag write uses the old CondExReg.
  - Evaluation uses the old Flags.
  - Both registers update at the same edge.
- Before the first Decode after reset, CondExReg=0: RegWrite, MemWrite and the PCS term are suppressed.
- Consecutive IRWrite cycles: each one re-arms dec_cyc; the last captured verdict wins.
- X on Cond, FlagW or ALUFlags while their enables are inactive has no effect on state.

Test Plan:
- Reset with FLAG_RESET=0 → Flags=0000, CondExReg=0. Then RegW=1, MemW=1, PCS=1, NextPC=0 → RegWrite=0, MemWrite=0, PCWrite=0.
- Flags=0100 (Z=1), Cond=0000 (EQ), IRWrite pulse → CondExReg=1 one cycle after dec_cyc. With Cond=0001 (NE) → CondExReg=0. RegW=1 → RegWrite follows CondExReg.
- CMP sequence: CondExReg=1, FlagW=11, ALUFlags=1001, NoWrite=1, RegW=1 → Flags=1001 next cycle, RegWrite=0 throughout.
- FlagW=10 with ALUFlags=0111 from Flags=1001 → Flags=0101 (C,V kept). Repeat with CondExReg=0 → Flags unchanged.
- Verdict hold: Cond=1011 (LT) with Flags N=1, V=0 → CondExReg=1. Then update Flags so N==V mid-instruction → CondExReg stays 1 until the next dec_cyc.
- Branch not taken: Cond=0000, Z=0, PCS=1, NextPC=0 → PCWrite=0. NextPC=1 → PCWrite=1 regardless. Assert Reset mid-Execute → Flags=FLAG_RESET, CondExReg=0 next cycle.

Source files
------------

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, latches the Cond verdict in the Decode cycle
// and gates the decoder's raw write enables with that verdict.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET   = 4'b0000,
  parameter bit         COND_NV_EXEC = 1'b0
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NextPC,
  input  logic       IRWrite,
  input  logic       NoWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondExReg
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       dec_cyc_q;
  logic       cond_ex;

  logic n_flag, z_flag, c_flag, v_flag;
  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  // Evaluated from the flag register only, never from the live ALU flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z_flag;
      4'b0001: cond_ex = ~z_flag;
      4'b0010: cond_ex = c_flag;
      4'b0011: cond_ex = ~c_flag;
      4'b0100: cond_ex = n_flag;
      4'b0101: cond_ex = ~n_flag;
      4'b0110: cond_ex = v_flag;
      4'b0111: cond_ex = ~v_flag;
      4'b1000: cond_ex = c_flag & ~z_flag;
      4'b1001: cond_ex = ~c_flag | z_flag;
      4'b1010: cond_ex = (n_flag == v_flag);
      4'b1011: cond_ex = (n_flag != v_flag);
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = COND_NV_EXEC;
    endcase
  end

  // Flag writes are qualified by the verdict already held, not the one being captured.
  always_comb begin
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    if (dec_cyc_q) begin
      cond_ex_d = cond_ex;
    end
    if (FlagW[1] && cond_ex_q) begin
      flags_d[3:2] = ALUFlags[3:2];
    end
    if (FlagW[0] && cond_ex_q) begin
      flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      flags_q   <= FLAG_RESET;
      cond_ex_q <= 1'b0;
      dec_cyc_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      dec_cyc_q <= IRWrite;
    end
  end

  always_comb begin
    PCWrite   = NextPC | (PCS & cond_ex_q);
    RegWrite  = RegW & cond_ex_q & ~NoWrite;
    MemWrite  = MemW & cond_ex_q;
    Flags     = flags_q;
    CondExReg = cond_ex_q;
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: per-cycle expectations are queued as stimulus is
// driven and compared against outputs sampled on the falling edge.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       Reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NextPC, IRWrite, NoWrite;
  logic       PCWrite, RegWrite, MemWrite, CondExReg;
  logic [3:0] Flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;  // {Flags, CondExReg, PCWrite, RegWrite, MemWrite}
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];

  cond_logic #(
    .FLAG_RESET  (4'b0000),
    .COND_NV_EXEC(1'b0)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NextPC   (NextPC),
    .IRWrite  (IRWrite),
    .NoWrite  (NoWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondExReg(CondExReg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reference condition evaluator, organised by condition pair with an invert bit.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: return c[0] ? 1'b0 : 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic idle();
    Reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'($urandom); FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NextPC = 1'b0; IRWrite = 1'b0; NoWrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with the current inputs; queue the expected outputs and record the observed.
  task automatic sample(input string tag, input logic [7:0] e);
    ent_t x;
    x.tag = tag; x.v = e;
    exp_q.push_back(x);
    @(negedge clk);
    x.v = {Flags, CondExReg, PCWrite, RegWrite, MemWrite};
    obs_q.push_back(x);
    tick();
  endtask

  task automatic decode(input logic [3:0] c);
    Cond = c; IRWrite = 1'b1; tick();
    IRWrite = 1'b0; tick();
  endtask

  // Leaves CondExReg=1 and Flags=v.
  task automatic set_flags(input logic [3:0] v);
    FlagW = 2'b00;
    decode(4'b1110);
    FlagW = 2'b11; ALUFlags = v; tick();
    FlagW = 2'b00; ALUFlags = 4'($urandom);
  endtask

  task automatic test_reset();
    ent_t e, o;
    idle(); Reset = 1'b1; tick(); tick();
    Reset = 1'b0; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    sample("rst_gate", {4'b0000, 1'b0, 3'b000});
    sample("rst_gate2", {4'b0000, 1'b0, 3'b000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.tag, o.v, e.v);
      end
    end
  endtask

  task automatic test_eval();
    ent_t e, o;
    logic [3:0] pats [4] = '{4'b0100, 4'b1001, 4'b0010, 4'b1101};
    logic m;
    idle();
    set_flags(4'b0100);
    decode(4'b0001); RegW = 1'b1;
    sample("ne_z1", {4'b0100, 1'b0, 3'b000});
    RegW = 1'b0; decode(4'b0000); RegW = 1'b1;
    sample("eq_z1", {4'b0100, 1'b1, 3'b010});
    for (int p = 0; p < 4; p++) begin
      RegW = 1'b0;
      set_flags(pats[p]);
      for (int c = 0; c < 16; c++) begin
        RegW = 1'b0;
        decode(4'(c));
        m = ref_cond(4'(c), pats[p]);
        RegW = 1'b1; MemW = 1'b1;
        sample($sformatf("cond%0d_f%b", c, pats[p]), {pats[p], m, 1'b0, m, m});
        MemW = 1'b0;
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.tag, o.v, e.v);
      end
    end
  endtask

  task automatic test_cmp_and_partial();
    ent_t e, o;
    idle();
    set_flags(4'b0000);
    FlagW = 2'b11; ALUFlags = 4'b1001; NoWrite = 1'b1; RegW = 1'b1;
    sample("cmp_wr", {4'b0000, 1'b1, 3'b000});
    FlagW = 2'b00;
    sample("cmp_after", {4'b1001, 1'b1, 3'b000});
    NoWrite = 1'b0; RegW = 1'b0;
    FlagW = 2'b10; ALUFlags = 4'b0111;
    sample("nz_only_wr", {4'b1001, 1'b1, 3'b000});
    FlagW = 2'b00;
    sample("nz_only", {4'b0101, 1'b1, 3'b000});
    decode(4'b0001);  // NE with Z=1 -> fail
    FlagW = 2'b10; ALUFlags = 4'b1010;
    sample("gated_nz", {4'b0101, 1'b0, 3'b000});
    FlagW = 2'b01; ALUFlags = 4'b1111;
    sample("gated_cv", {4'b0101, 1'b0, 3'b000});
    FlagW = 2'b00;
    sample("gated_hold", {4'b0101, 1'b0, 3'b000});
    decode(4'b1110);
    FlagW = 2'b01; ALUFlags = 4'b1010;
    sample("cv_only_wr", {4'b0101, 1'b1, 3'b000});
    FlagW = 2'b00;
    sample("cv_only", {4'b0110, 1'b1, 3'b000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.tag, o.v, e.v);
      end
    end
  endtask

  task automatic test_hold();
    ent_t e, o;
    idle();
    set_flags(4'b1000);
    decode(4'b1011);
    sample("lt_pass", {4'b1000, 1'b1, 3'b000});
    FlagW = 2'b11; ALUFlags = 4'b0000;
    sample("lt_flagwr", {4'b1000, 1'b1, 3'b000});
    FlagW = 2'b00;
    sample("lt_hold1", {4'b0000, 1'b1, 3'b000});
    sample("lt_hold2", {4'b0000, 1'b1, 3'b000});
    decode(4'b1011);
    sample("lt_redecode", {4'b0000, 1'b0, 3'b000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.tag, o.v, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e, o;
    idle();
    set_flags(4'b0000);
    // Two IRWrite cycles in a row: the later decode cycle wins.
    Cond = 4'b0000; IRWrite = 1'b1; tick();
    Cond = 4'b1110; IRWrite = 1'b1; tick();
    Cond = 4'b0000; IRWrite = 1'b0;
    sample("b2b_mid", {4'b0000, 1'b1, 3'b000});
    sample("b2b_last", {4'b0000, 1'b0, 3'b000});
    // Decode and flag write at the same edge, old verdict = 0: flags held, AL captured.
    Cond = 4'b1110; IRWrite = 1'b1; tick();
    IRWrite = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1111;
    sample("sim_old0", {4'b0000, 1'b0, 3'b000});
    FlagW = 2'b00;
    sample("sim_old0_after", {4'b0000, 1'b1, 3'b000});
    // Old verdict = 1: flags written, NE evaluated on the old Z=0.
    Cond = 4'b0001; IRWrite = 1'b1; tick();
    IRWrite = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0100;
    sample("sim_old1", {4'b0000, 1'b1, 3'b000});
    FlagW = 2'b00;
    sample("sim_old1_after", {4'b0100, 1'b1, 3'b000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.tag, o.v, e.v);
      end
    end
  endtask

  task automatic test_branch_reset();
    ent_t e, o;
    idle();
    set_flags(4'b0000);
    decode(4'b0000);
    PCS = 1'b1; NextPC = 1'b0;
    sample("br_not_taken", {4'b0000, 1'b0, 3'b000});
    NextPC = 1'b1;
    sample("br_nextpc", {4'b0000, 1'b0, 3'b100});
    NextPC = 1'b0;
    decode(4'b1110);
    MemW = 1'b1;
    sample("br_taken", {4'b0000, 1'b1, 3'b101});
    FlagW = 2'b11; ALUFlags = 4'b1100;
    sample("exe_flagwr", {4'b0000, 1'b1, 3'b101});
    // Reset mid-Execute with a flag write and a fresh fetch pending.
    Reset = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0011; IRWrite = 1'b1;
    sample("rst_cycle", {4'b1100, 1'b1, 3'b101});
    Reset = 1'b0; FlagW = 2'b00; IRWrite = 1'b0;
    sample("rst_after", {4'b0000, 1'b0, 3'b000});
    sample("rst_no_capture", {4'b0000, 1'b0, 3'b000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.tag, o.v, e.v);
      end
    end
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    test_reset();
    test_eval();
    test_cmp_and_partial();
    test_hold();
    test_back_to_back();
    test_branch_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
